// File: rtl/sha_top.sv
// sha_top: multi-block SHA-256 core, one compression round per clock over a sliding 16-word schedule window.
module sha_top (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_enable,
    input  logic [511:0] data_in,
    input  logic [7:0]   i_N,
    output logic         o_done,
    output logic [255:0] data_out
);
    typedef enum logic [2:0] {IDLE, ROUND, UPDATE, GAP1, GAP2, LOAD, DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state, state_nx;
    logic [7:0]  i;
    logic [7:0]  n_lat;
    logic [5:0]  t;
    logic [31:0] w  [16];
    logic [31:0] v  [8];
    logic [31:0] hh [8];
    logic [31:0] hs [8];
    logic [31:0] t1, t2, w_nx;
    logic        start, last;

    assign start = (state == IDLE || state == DONE) && i_enable && i_N != 8'd0;
    assign last  = (i + 8'd1) == n_lat;

    always_comb begin
        t1   = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[0];
        t2   = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        w_nx = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        for (int j = 0; j < 8; j++) hs[j] = hh[j] + v[j];
    end

    always_comb begin
        state_nx = state;
        if (start) state_nx = ROUND;
        else case (state)
            ROUND:   state_nx = (t == 6'd63) ? UPDATE : ROUND;
            UPDATE:  state_nx = last ? DONE : GAP1;
            GAP1:    state_nx = GAP2;
            GAP2:    state_nx = LOAD;
            LOAD:    state_nx = ROUND;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i        <= '0;
            n_lat    <= '0;
            t        <= '0;
            o_done   <= 1'b0;
            data_out <= '0;
            for (int j = 0; j < 16; j++) w[j] <= '0;
            for (int j = 0; j < 8; j++) begin
                v[j]  <= '0;
                hh[j] <= '0;
            end
        end else if (start) begin
            i      <= '0;
            n_lat  <= i_N;
            t      <= '0;
            o_done <= 1'b0;
            for (int j = 0; j < 16; j++) w[j] <= data_in[511-32*j -: 32];
            for (int j = 0; j < 8; j++) begin
                v[j]  <= IV[j];
                hh[j] <= IV[j];
            end
        end else begin
            case (state)
                ROUND: begin
                    t    <= t + 6'd1;
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    for (int j = 0; j < 15; j++) w[j] <= w[j+1];
                    w[15] <= w_nx;
                end
                UPDATE: begin
                    i <= i + 8'd1;
                    for (int j = 0; j < 8; j++) hh[j] <= hs[j];
                    if (last) begin
                        o_done <= 1'b1;
                        for (int j = 0; j < 8; j++) data_out[255-32*j -: 32] <= hs[j];
                    end
                end
                LOAD: begin
                    t <= '0;
                    for (int j = 0; j < 16; j++) w[j] <= data_in[511-32*j -: 32];
                    for (int j = 0; j < 8; j++) v[j] <= hh[j];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha_top.sv
// tb_sha_top: scoreboard bench for sha_top using NIST vectors, start/latency, noise, reset and N=0 cases.
module tb_sha_top;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_enable = 1'b0;
    logic [511:0] data_in = '0;
    logic [7:0]   i_N = '0;
    logic         o_done;
    logic [255:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [255:0] sb [$];
    logic [255:0] last_dig;

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'b0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'b0};
    localparam logic [511:0] B_TWO0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO1  = {480'b0, 32'h000001c0};

    sha_top dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .data_in(data_in),
        .i_N(i_N), .o_done(o_done), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input int n, input logic [511:0] b0, input logic [511:0] b1,
                       input logic [255:0] exp, input bit noisy);
        int cyc;
        logic [7:0] seen;
        @(negedge clk);
        data_in  = b0;
        i_N      = n[7:0];
        i_enable = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1 i_enable = 1'b0;
        cyc  = 0;
        seen = 8'd0;
        while (!o_done && cyc < 400) begin
            @(posedge clk);
            #1 cyc++;
            if (noisy) begin
                i_enable = (cyc % 3 == 0);
                if (cyc > 2 && cyc < 60) begin
                    data_in = {16{$urandom}};
                    i_N     = 8'($urandom_range(0, 255));
                end
            end
            if (dut.i != seen && !o_done) begin
                seen = dut.i;
                check("mid_done", {255'b0, o_done}, 256'd0);
                check("mid_dout", data_out, last_dig);
                @(posedge clk);
                #1 cyc++;
                data_in = b1;
            end
        end
        i_enable = 1'b0;
        check("done", {255'b0, o_done}, 256'd1);
        check("latency", 256'(cyc), 256'(65 + 68 * (n - 1)));
        if (sb.size() != 0) check("digest", data_out, sb.pop_front());
        repeat (5) @(posedge clk);
        #1 check("hold_done", {255'b0, o_done}, 256'd1);
        check("hold_dout", data_out, exp);
        last_dig = exp;
    endtask

    initial begin
        bit seen_done;
        last_dig = '0;
        repeat (3) @(posedge clk);
        #1 check("rst_done", {255'b0, o_done}, 256'd0);
        check("rst_dout", data_out, 256'd0);
        check("rst_i", 256'(dut.i), 256'd0);
        rst_n = 1'b1;

        @(negedge clk);
        i_N = 8'd0;
        i_enable = 1'b1;
        data_in = B_ABC;
        seen_done = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1 seen_done |= o_done;
        end
        i_enable = 1'b0;
        check("n0_done", {255'b0, seen_done}, 256'd0);
        check("n0_i", 256'(dut.i), 256'd0);

        run(1, B_ABC, '0, D_ABC, 1'b0);
        run(1, B_EMPTY, '0, D_EMPTY, 1'b0);
        run(1, B_ABC, '0, D_ABC, 1'b0);
        run(2, B_TWO0, B_TWO1, D_TWO, 1'b0);
        run(1, B_ABC, '0, D_ABC, 1'b1);

        @(negedge clk);
        data_in = B_ABC;
        i_N = 8'd1;
        i_enable = 1'b1;
        @(posedge clk);
        #1 i_enable = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_done", {255'b0, o_done}, 256'd0);
        check("arst_dout", data_out, 256'd0);
        check("arst_i", 256'(dut.i), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_dig = '0;
        run(1, B_ABC, '0, D_ABC, 1'b0);

        check("sb_empty", 256'(sb.size()), 256'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha_top.md
Name: sha_top

Overview:
- Multi-block SHA-256 hashing core (FIPS 180-4).
- Accepts pre-padded 512-bit message blocks one at a time on a shared input bus, for a block count supplied at start.
- Runs 64 compression rounds per block, one round per clock, and presents the 256-bit digest with a done flag.
- Used as a standalone hash engine; the upstream feeder presents each block on data_in while tracking the internal block index `i`.

Parameters:
- None. Widths are fixed by SHA-256.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- i_enable  input  1  start strobe, sampled in IDLE only
- data_in  input  512  current message block, big-endian: W0 = data_in[511:480] ... W15 = data_in[31:0]
- i_N  input  8  number of 512-bit blocks in the message (1..255)
- o_done  output  1  digest valid, held high until next start
- data_out  output  256  digest H0..H7, H0 = data_out[255:224]

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Internal 8-bit register named `i` holds the index of the block being processed. Its name and width are fixed because feeders and benches probe it hierarchically.
- Reset (any time, including mid-hash): state=IDLE, i=0, o_done=0, data_out=0, working and H registers=0.
- States: IDLE, ROUND, UPDATE, GAP1, GAP2, LOAD, DONE. DONE behaves as IDLE with o_done held.
- Start sequence:
  - Start edge E: state IDLE/DONE, i_enable=1, i_N!=0.
  - On E: latch i_N, capture data_in into the 16-word schedule window, set H0..H7 and a..h to the standard IV (6a09e667 ... 5be0cd19), set i=0, clear o_done, go to ROUND with t=0.
- i_enable while i_N==0 is ignored and the block stays in IDLE. i_enable in any busy state is ignored.
- ROUND (64 edges, t=0..63), per edge:
  - T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]
  - T2 = Σ0(a)+Maj(a,b,c)
  - Shift working registers.
  - W[t] for t>=16 = σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16], computed in a sliding 16-word window.
  - All additions are mod 2^32.
- UPDATE (1 edge): Hn = Hn + working register, mod 2^32; i = i+1.
  - If i+1 == latched N: data_out = new H, o_done = 1, go to DONE.
  - Otherwise go to GAP1.
- GAP1 and GAP2: one idle edge each. They give the feeder two cycles after `i` changes to drive the next block.
- LOAD (1 edge): capture data_in into the schedule window, set a..h = H, go to ROUND t=0.
- Timing relative to start edge E:
  - Block 0 rounds on E+1..E+64; UPDATE on E+65.
  - Block k>=1: captured on edge E+68k; its UPDATE on E+65+68k.
  - For N blocks, o_done rises after edge E+65+68(N-1). N=1: visible after E+65. N=2: after E+133.
- Feeder requirement: data_in for block k>=1 is sampled only at LOAD, which is the 3rd edge after the edge on which `i` became k.
- o_done and data_out stay stable in DONE until a new start or reset.
- A new start from DONE re-initialises H to the IV; no state carries over between messages.
- data_out is not updated during intermediate blocks and keeps its previous value.
- K[0..63] is a constant ROM per FIPS 180-4.

Test Plan:
- Two-block NIST vector "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". i_N=2. Block0 = 61626364...6e6f7071 80000000 00000000. Block1 = zeros with last word 000001C0, driven one cycle after `i` becomes 1. -> o_done=1 at E+133; data_out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Single block "abc" (61626380, zeros, last word 00000018), i_N=1. -> o_done after E+65; data_out = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (80000000, then zeros), i_N=1. -> data_out = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855. Then restart with "abc" -> abc digest, showing no state carry-over.
- i_enable pulsed repeatedly mid-hash, and data_in changed during ROUND. -> no effect; "abc" digest unchanged, latency unchanged.
- rst_n low at round 30, then released. -> o_done=0, data_out=0, i=0 immediately. A fresh "abc" run gives the correct digest.
- i_N=0 with i_enable=1. -> stays IDLE; o_done remains 0 for 100 cycles.
